div_sign_restore: RTL and testbench
===================================

// Module: div_sign_restore
// PURPOSE
//  Post-processing end of the signed divide path. Operand conditioning strips the sign
//  (magnitude + sign flag per operand); this block takes the unsigned quotient/remainder
//  magnitudes from the divider core and restores two's-complement results.
//  Applies RISC-V DIV/REM fix-ups (divide-by-zero, overflow) in a 2-stage elastic
//  valid/ready pipeline, so the divider core can retire one result per cycle.
// PARAMETERS
//  WIDTH  32  data width of quotient, remainder, dividend
//  TAG_W  4   width of opaque tag carried alongside each result
// PORTS
//  clock          in   1      single clock; all state on rising edge
//  reset          in   1      asynchronous, active-low reset
//  io_kill        in   1      synchronous flush of both stages
//  io_in_valid    in   1      input beat valid
//  io_in_ready    out  1      input beat accepted when valid&ready
//  io_in_quot     in   WIDTH  unsigned quotient magnitude
//  io_in_rem      in   WIDTH  unsigned remainder magnitude
//  io_in_aSign    in   1      dividend was negative (signed op only)
//  io_in_bSign    in   1      divisor was negative (signed op only)
//  io_in_divZero  in   1      divisor was zero
//  io_in_dividend in   WIDTH  original (unconditioned) dividend
//  io_in_tag      in   TAG_W  passthrough tag
//  io_out_valid   out  1      result valid
//  io_out_ready   in   1      downstream accepts result
//  io_out_quot    out  WIDTH  signed quotient
//  io_out_rem     out  WIDTH  signed remainder
//  io_out_tag     out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (reset==0): s1_valid=s2_valid=0, all data/tag regs 0; io_out_valid=0,
//    io_out_*=0, io_in_ready=0 while reset is held; io_in_ready=1 first cycle after release.
//  - Stage 1 (S1) registers the input beat. Stage 2 (S2) registers the restored result
//    and drives io_out_* directly from flops (no comb path from io_in_* to io_out_*).
//  - adv2 = !s2_valid | io_out_ready; adv1 = !s1_valid | adv2; io_in_ready = adv1 & !io_kill.
//  - S1 loads on io_in_valid&io_in_ready; S2 loads S1 when s1_valid&adv2; S1 clears when it
//    moves to S2 without new input. Holding rule: io_out_* stable while valid & !ready.
//  - Latency 2 cycles accept->out_valid with ready high; throughput 1 beat/cycle; FIFO order.
//  - Restore (computed between S1 and S2, mod 2^WIDTH):
//    divZero=1: quot = all-ones; rem = dividend (signs ignored).
//    else: quot = (aSign^bSign) ? 0-quot : quot; rem = aSign ? 0-rem : rem.
//  - Overflow (-2^(W-1) / -1): magnitudes q=2^(W-1), r=0, signs equal -> quot=2^(W-1),
//    rem=0 with no special case; must not be altered.
//  - Zero magnitude with sign set negates to 0 (no -0).
//  - io_kill: next edge clears s1_valid and s2_valid; input offered same cycle is dropped
//    (io_in_ready=0); data regs may hold stale values. io_out_valid=0 the cycle after kill.
//  - Unsigned ops: upstream drives aSign=bSign=0; block does not know op signedness.
//  - Reset assertion mid-operation clears all state immediately (async); in-flight lost.
// TESTING
//  T1 q=3,r=1,aSign=1,bSign=0,divZero=0 (-7/2) -> 2 cycles later quot=0xFFFFFFFD, rem=0xFFFFFFFF.
//  T2 divZero=1, dividend=0xFFFFFFF9, q=r=0x5A5A5A5A -> quot=0xFFFFFFFF, rem=0xFFFFFFF9.
//  T3 q=0x80000000,r=0,aSign=1,bSign=1 -> quot=0x80000000, rem=0; q=0,aSign=1 -> quot=0.
//  T4 out_ready=0 for 5 cycles, 4 beats offered back-to-back (tags 1..4) -> tags 1,2
//     accepted, in_ready=0 thereafter, out_* stable; release -> tags 1,2,3,4 in order, no loss.
//  T5 both stages full, io_kill=1 with io_in_valid=1 -> next cycle out_valid=0, nothing
//     accepted that cycle, in_ready=1 after; subsequent beat emerges with correct tag.
//  T6 reset asserted mid-stream with out_valid=1 -> out_valid, out_quot, out_rem,
//     out_tag = 0 asynchronously; normal T1 result after release.

Source files
------------

// File: rtl/div_sign_restore.sv
// Sign restoration and RISC-V DIV/REM fix-up for the signed divide path.
// Two-stage elastic valid/ready pipeline; outputs are driven straight from S2 flops.
module div_sign_restore #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_kill,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_quot,
  input  logic [WIDTH-1:0] io_in_rem,
  input  logic             io_in_aSign,
  input  logic             io_in_bSign,
  input  logic             io_in_divZero,
  input  logic [WIDTH-1:0] io_in_dividend,
  input  logic [TAG_W-1:0] io_in_tag,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_quot,
  output logic [WIDTH-1:0] io_out_rem,
  output logic [TAG_W-1:0] io_out_tag
);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  logic             run_q, run_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_quot_q, s1_quot_d;
  logic [WIDTH-1:0] s1_rem_q, s1_rem_d;
  logic             s1_asign_q, s1_asign_d;
  logic             s1_bsign_q, s1_bsign_d;
  logic             s1_divzero_q, s1_divzero_d;
  logic [WIDTH-1:0] s1_dividend_q, s1_dividend_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_quot_q, s2_quot_d;
  logic [WIDTH-1:0] s2_rem_q, s2_rem_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             adv1, adv2, in_fire;
  logic [WIDTH-1:0] rest_quot, rest_rem;

  // run_q keeps io_in_ready low until the first edge after reset release.
  assign adv2        = !s2_valid_q | io_out_ready;
  assign adv1        = !s1_valid_q | adv2;
  assign io_in_ready = run_q & adv1 & !io_kill;
  assign in_fire     = io_in_valid & io_in_ready;

  // Restore two's-complement results from the S1 magnitudes.
  always_comb begin
    rest_quot = s1_quot_q;
    rest_rem  = s1_rem_q;
    if (s1_divzero_q) begin
      rest_quot = {WIDTH{1'b1}};
      rest_rem  = s1_dividend_q;
    end else begin
      rest_quot = (s1_asign_q ^ s1_bsign_q) ? negate(s1_quot_q) : s1_quot_q;
      rest_rem  = s1_asign_q ? negate(s1_rem_q) : s1_rem_q;
    end
  end

  // Next-state for both pipeline stages.
  always_comb begin
    run_d         = 1'b1;
    s1_valid_d    = s1_valid_q;
    s1_quot_d     = s1_quot_q;
    s1_rem_d      = s1_rem_q;
    s1_asign_d    = s1_asign_q;
    s1_bsign_d    = s1_bsign_q;
    s1_divzero_d  = s1_divzero_q;
    s1_dividend_d = s1_dividend_q;
    s1_tag_d      = s1_tag_q;
    s2_valid_d    = s2_valid_q;
    s2_quot_d     = s2_quot_q;
    s2_rem_d      = s2_rem_q;
    s2_tag_d      = s2_tag_q;
    if (io_kill) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_d    = 1'b1;
        s1_quot_d     = io_in_quot;
        s1_rem_d      = io_in_rem;
        s1_asign_d    = io_in_aSign;
        s1_bsign_d    = io_in_bSign;
        s1_divzero_d  = io_in_divZero;
        s1_dividend_d = io_in_dividend;
        s1_tag_d      = io_in_tag;
      end else if (adv2) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (adv2) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_quot_d = rest_quot;
          s2_rem_d  = rest_rem;
          s2_tag_d  = s1_tag_q;
        end else begin
          s2_quot_d = s2_quot_q;
        end
      end else begin
        s2_valid_d = s2_valid_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_quot_q     <= {WIDTH{1'b0}};
      s1_rem_q      <= {WIDTH{1'b0}};
      s1_asign_q    <= 1'b0;
      s1_bsign_q    <= 1'b0;
      s1_divzero_q  <= 1'b0;
      s1_dividend_q <= {WIDTH{1'b0}};
      s1_tag_q      <= {TAG_W{1'b0}};
      s2_valid_q    <= 1'b0;
      s2_quot_q     <= {WIDTH{1'b0}};
      s2_rem_q      <= {WIDTH{1'b0}};
      s2_tag_q      <= {TAG_W{1'b0}};
    end else begin
      run_q         <= run_d;
      s1_valid_q    <= s1_valid_d;
      s1_quot_q     <= s1_quot_d;
      s1_rem_q      <= s1_rem_d;
      s1_asign_q    <= s1_asign_d;
      s1_bsign_q    <= s1_bsign_d;
      s1_divzero_q  <= s1_divzero_d;
      s1_dividend_q <= s1_dividend_d;
      s1_tag_q      <= s1_tag_d;
      s2_valid_q    <= s2_valid_d;
      s2_quot_q     <= s2_quot_d;
      s2_rem_q      <= s2_rem_d;
      s2_tag_q      <= s2_tag_d;
    end
  end

  assign io_out_valid = s2_valid_q;
  assign io_out_quot  = s2_quot_q;
  assign io_out_rem   = s2_rem_q;
  assign io_out_tag   = s2_tag_q;

endmodule

// File: tb/tb_div_sign_restore.sv
// Directed-vector bench for div_sign_restore: sign restore, fix-ups, backpressure,
// kill and asynchronous reset, all with hand-computed expectations.
module tb_div_sign_restore;

  logic        clock;
  logic        reset;
  logic        io_kill;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_quot;
  logic [31:0] io_in_rem;
  logic        io_in_aSign;
  logic        io_in_bSign;
  logic        io_in_divZero;
  logic [31:0] io_in_dividend;
  logic [3:0]  io_in_tag;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_quot;
  logic [31:0] io_out_rem;
  logic [3:0]  io_out_tag;

  int checks = 0;
  int errors = 0;

  div_sign_restore #(.WIDTH(32), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .io_kill(io_kill),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_quot(io_in_quot), .io_in_rem(io_in_rem),
    .io_in_aSign(io_in_aSign), .io_in_bSign(io_in_bSign),
    .io_in_divZero(io_in_divZero), .io_in_dividend(io_in_dividend),
    .io_in_tag(io_in_tag),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_quot(io_out_quot), .io_out_rem(io_out_rem), .io_out_tag(io_out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic [31:0] q, input logic [31:0] r, input logic a,
                          input logic b, input logic dz, input logic [31:0] dvd,
                          input logic [3:0] tg);
    io_in_valid    = 1'b1;
    io_in_quot     = q;
    io_in_rem      = r;
    io_in_aSign    = a;
    io_in_bSign    = b;
    io_in_divZero  = dz;
    io_in_dividend = dvd;
    io_in_tag      = tg;
  endtask

  // One isolated beat with out_ready high: accepted, invisible one cycle, visible after two.
  task automatic run_one(input string nm, input logic [31:0] q, input logic [31:0] r,
                         input logic a, input logic b, input logic dz,
                         input logic [31:0] dvd, input logic [3:0] tg,
                         input logic [31:0] eq, input logic [31:0] er);
    @(negedge clock);
    set_beat(q, r, a, b, dz, dvd, tg);
    #1 check({nm, "_in_ready"}, 32'(io_in_ready), 32'd1);
    @(negedge clock);
    io_in_valid = 1'b0;
    #1 check({nm, "_lat1_valid"}, 32'(io_out_valid), 32'd0);
    @(negedge clock);
    #1;
    check({nm, "_valid"}, 32'(io_out_valid), 32'd1);
    check({nm, "_quot"}, io_out_quot, eq);
    check({nm, "_rem"}, io_out_rem, er);
    check({nm, "_tag"}, 32'(io_out_tag), 32'(tg));
  endtask

  initial begin
    int nt;
    int rcv;
    reset = 1'b0; io_kill = 1'b0; io_out_ready = 1'b1;
    set_beat(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    io_in_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_out_valid", 32'(io_out_valid), 32'd0);
    check("rst_out_quot", io_out_quot, 32'd0);
    check("rst_out_rem", io_out_rem, 32'd0);
    check("rst_out_tag", 32'(io_out_tag), 32'd0);
    check("rst_in_ready", 32'(io_in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    #1 check("rel_in_ready", 32'(io_in_ready), 32'd1);

    // T1..T3 and extra sign patterns
    run_one("t1", 32'd3, 32'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_one("t2", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 4'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_one("t3_ovf", 32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 4'd3,
            32'h8000_0000, 32'd0);
    run_one("t3_zero", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd4, 32'd0, 32'd0);
    run_one("bneg", 32'd7, 32'd2, 1'b0, 1'b1, 1'b0, 32'd16, 4'd5, 32'hFFFF_FFF9, 32'd2);
    run_one("unsigned", 32'd10, 32'd3, 1'b0, 1'b0, 1'b0, 32'd33, 4'd6, 32'd10, 32'd3);

    // T4: backpressure, four beats offered back-to-back
    nt = 1;
    rcv = 0;
    for (int c = 0; c < 40 && rcv < 4; c++) begin
      @(negedge clock);
      io_out_ready = (c >= 5);
      if (nt <= 4) set_beat(32'(nt), 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'(nt));
      else io_in_valid = 1'b0;
      #1;
      if (c >= 2 && c <= 4) begin
        check("t4_stall_in_ready", 32'(io_in_ready), 32'd0);
        check("t4_hold_valid", 32'(io_out_valid), 32'd1);
        check("t4_hold_tag", 32'(io_out_tag), 32'd1);
        check("t4_hold_quot", io_out_quot, 32'd1);
      end
      if (c == 4) check("t4_accepted", 32'(nt), 32'd3);
      if (io_out_valid && io_out_ready) begin
        check("t4_order", 32'(io_out_tag), 32'(rcv + 1));
        check("t4_data", io_out_quot, 32'(rcv + 1));
        rcv++;
      end
      if (io_in_valid && io_in_ready) nt++;
    end
    io_in_valid = 1'b0;
    check("t4_count", 32'(rcv), 32'd4);

    // T5: kill with both stages full and input offered
    @(negedge clock);
    io_out_ready = 1'b0;
    set_beat(32'd6, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd6);
    @(negedge clock);
    set_beat(32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd7);
    @(negedge clock);
    io_in_valid = 1'b0;
    #1;
    check("t5_full_valid", 32'(io_out_valid), 32'd1);
    check("t5_full_tag", 32'(io_out_tag), 32'd6);
    check("t5_full_in_ready", 32'(io_in_ready), 32'd0);
    io_out_ready = 1'b1;
    #1 check("t5_drain_ready", 32'(io_in_ready), 32'd1);
    io_kill = 1'b1;
    set_beat(32'd8, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd8);
    #1 check("t5_kill_in_ready", 32'(io_in_ready), 32'd0);
    @(negedge clock);
    io_kill = 1'b0;
    io_in_valid = 1'b0;
    #1;
    check("t5_post_kill_valid", 32'(io_out_valid), 32'd0);
    check("t5_post_kill_ready", 32'(io_in_ready), 32'd1);
    run_one("t5_next", 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd9, 32'd9, 32'd0);

    // T6: asynchronous reset mid-stream
    @(negedge clock);
    set_beat(32'd3, 32'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 4'd12);
    @(negedge clock);
    io_in_valid = 1'b0;
    @(negedge clock);
    #1 check("t6_pre_valid", 32'(io_out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(io_out_valid), 32'd0);
    check("t6_rst_quot", io_out_quot, 32'd0);
    check("t6_rst_rem", io_out_rem, 32'd0);
    check("t6_rst_tag", 32'(io_out_tag), 32'd0);
    check("t6_rst_in_ready", 32'(io_in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1 check("t6_rel_in_ready", 32'(io_in_ready), 32'd1);
    run_one("t6_t1", 32'd3, 32'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 4'd13,
            32'hFFFF_FFFD, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
